led_pattern_gen: RTL and testbench

Parametrised LED pattern generator for the board LED bank. It is the next-generation replacement for the fixed 16-bit rotating-LED block. An internal prescaler produces a one-cycle step enable, so the block uses no derived clock. The block supports any LED width and four run-time-selectable patterns: rotate, bounce, fill/drain and hold. It drives the LED pins directly and also gives the top level a direction status and a pattern-wrap pulse.

---
 rtl/led_pattern_gen_if.sv | 30 +++
 rtl/led_pattern_gen.sv | 167 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_if.sv
// LED pattern generator control/status bundle.
// The controller drives run controls, the generator drives LED status.
interface led_pattern_gen_if #(
  parameter int WIDTH = 16
) ();
  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic [WIDTH-1:0] led;
  logic             dir_out;
  logic             wrap;

  modport master (
    output en,
    output dir,
    output mode,
    input  led,
    input  dir_out,
    input  wrap
  );

  modport slave (
    input  en,
    input  dir,
    input  mode,
    output led,
    output dir_out,
    output wrap
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern generator: rotate, bounce, fill/drain, hold.
// A prescaler yields a one-cycle step enable; no derived clock.
module led_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 25
) (
  input logic             clk,
  input logic             rst,
  led_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    M_ROT  = 2'b00,
    M_BNC  = 2'b01,
    M_FILL = 2'b10,
    M_HOLD = 2'b11
  } mode_e;

  typedef enum logic {
    MOVE_DN = 1'b0,
    MOVE_UP = 1'b1
  } bdir_e;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } phase_e;

  localparam logic [WIDTH-1:0] SEED = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [DIV_W-1:0] CMAX = '1;

  logic [DIV_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  mode_e            mode_q, mode_in;
  bdir_e            bdir, bdir_d;
  phase_e           phase, phase_d;
  logic             dout_q, dout_d;
  logic             wrap_q, wrap_d;
  logic             step;
  logic             mode_chg;

  assign mode_in  = mode_e'(bus.mode);
  assign mode_chg = (mode_in != mode_q);
  assign step     = bus.en && (cnt == CMAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      led_q  <= SEED;
      mode_q <= M_ROT;
      bdir   <= MOVE_DN;
      phase  <= FILL;
      dout_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      led_q  <= led_d;
      mode_q <= mode_in;
      bdir   <= bdir_d;
      phase  <= phase_d;
      dout_q <= dout_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    cnt_d   = cnt;
    led_d   = led_q;
    bdir_d  = bdir;
    phase_d = phase;
    wrap_d  = 1'b0;
    if (mode_chg) begin
      // A mode change reseeds and restarts the step phase.
      cnt_d   = '0;
      bdir_d  = MOVE_DN;
      phase_d = FILL;
      unique case (mode_in)
        M_ROT:   led_d = SEED;
        M_BNC:   led_d = SEED;
        M_FILL:  led_d = '0;
        M_HOLD:  led_d = led_q;
        default: led_d = led_q;
      endcase
    end else if (bus.en) begin
      cnt_d = cnt + DIV_W'(1);
      if (step) begin
        unique case (mode_q)
          M_ROT: begin
            if (bus.dir) begin
              led_d  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
              wrap_d = led_q[WIDTH-1];
            end else begin
              led_d  = {led_q[0], led_q[WIDTH-1:1]};
              wrap_d = led_q[0];
            end
          end
          M_BNC: begin
            unique case (bdir)
              MOVE_DN: begin
                if (led_q[0]) begin
                  bdir_d = MOVE_UP;
                  led_d  = led_q << 1;
                  wrap_d = 1'b1;
                end else begin
                  led_d = led_q >> 1;
                end
              end
              MOVE_UP: begin
                if (led_q[WIDTH-1]) begin
                  bdir_d = MOVE_DN;
                  led_d  = led_q >> 1;
                  wrap_d = 1'b1;
                end else begin
                  led_d = led_q << 1;
                end
              end
              default: bdir_d = MOVE_DN;
            endcase
          end
          M_FILL: begin
            unique case (phase)
              FILL: begin
                if (led_q != ONES) begin
                  led_d = (led_q << 1) | LSB;
                end else begin
                  phase_d = DRAIN;
                  led_d   = led_q >> 1;
                  wrap_d  = 1'b1;
                end
              end
              DRAIN: begin
                if (led_q != '0) begin
                  led_d = led_q >> 1;
                end else begin
                  phase_d = FILL;
                  led_d   = LSB;
                  wrap_d  = 1'b1;
                end
              end
              default: phase_d = FILL;
            endcase
          end
          M_HOLD: led_d = led_q;
          default: led_d = led_q;
        endcase
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    unique case (mode_in)
      M_ROT:   dout_d = bus.dir;
      M_BNC:   dout_d = (bdir_d == MOVE_UP);
      M_FILL:  dout_d = (phase_d == FILL);
      M_HOLD:  dout_d = dout_q;
      default: dout_d = dout_q;
    endcase
  end

  assign bus.led     = led_q;
  assign bus.dir_out = dout_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with WIDTH=4, DIV_W=2.
// Expected step results are queued, then popped as steps occur.
module tb_led_pattern_gen;

  typedef struct {
    string      tag;
    logic [3:0] led;
    logic       dout;
    logic       wrap;
  } exp_t;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  exp_t q[$];

  led_pattern_gen_if #(.WIDTH(4)) bus ();

  led_pattern_gen #(
    .WIDTH(4),
    .DIV_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(string tag, logic [3:0] l, logic d, logic w);
    exp_t e;
    e.tag  = tag;
    e.led  = l;
    e.dout = d;
    e.wrap = w;
    q.push_back(e);
  endtask

  // Three quiet edges, then the step edge; compare against the queue head.
  task automatic run_step();
    exp_t e;
    tick(3);
    chk("quiet_wrap", 8'(bus.wrap), 8'd0);
    tick(1);
    if (q.size() == 0) begin
      total++;
      $error("FAIL sb_empty observed=0 expected=entry");
    end else begin
      e = q.pop_front();
      chk({e.tag, "_led"}, 8'(bus.led), 8'(e.led));
      chk({e.tag, "_wrap"}, 8'(bus.wrap), 8'(e.wrap));
      chk({e.tag, "_dir"}, 8'(bus.dir_out), 8'(e.dout));
    end
  endtask

  task automatic do_reset(logic [1:0] m, logic d);
    @(negedge clk);
    rst      = 1'b0;
    bus.en   = 1'b0;
    bus.mode = m;
    bus.dir  = d;
    #2;
    chk("rst_led", 8'(bus.led), 8'b1000);
    chk("rst_wrap", 8'(bus.wrap), 8'd0);
    chk("rst_dir", 8'(bus.dir_out), 8'd0);
    @(negedge clk);
    rst    = 1'b1;
    bus.en = 1'b1;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.dir  = 1'b1;
    bus.mode = 2'b00;

    // Rotate toward MSB
    do_reset(2'b00, 1'b1);
    push("rl1", 4'b0001, 1'b1, 1'b1);
    push("rl2", 4'b0010, 1'b1, 1'b0);
    push("rl3", 4'b0100, 1'b1, 1'b0);
    push("rl4", 4'b1000, 1'b1, 1'b0);
    push("rl5", 4'b0001, 1'b1, 1'b1);
    repeat (5) run_step();

    // Rotate toward LSB
    do_reset(2'b00, 1'b0);
    push("rr1", 4'b0100, 1'b0, 1'b0);
    push("rr2", 4'b0010, 1'b0, 1'b0);
    push("rr3", 4'b0001, 1'b0, 1'b0);
    push("rr4", 4'b1000, 1'b0, 1'b1);
    repeat (4) run_step();

    // Bounce from reset; mode change seeds on edge 1
    do_reset(2'b01, 1'b0);
    tick(1);
    chk("bnc_seed", 8'(bus.led), 8'b1000);
    push("b1", 4'b0100, 1'b0, 1'b0);
    push("b2", 4'b0010, 1'b0, 1'b0);
    push("b3", 4'b0001, 1'b0, 1'b0);
    push("b4", 4'b0010, 1'b1, 1'b1);
    push("b5", 4'b0100, 1'b1, 1'b0);
    push("b6", 4'b1000, 1'b1, 1'b0);
    push("b7", 4'b0100, 1'b0, 1'b1);
    repeat (7) run_step();

    // Fill/drain
    bus.mode = 2'b10;
    tick(1);
    chk("fd_seed", 8'(bus.led), 8'b0000);
    chk("fd_seed_dir", 8'(bus.dir_out), 8'd1);
    push("f1", 4'b0001, 1'b1, 1'b0);
    push("f2", 4'b0011, 1'b1, 1'b0);
    push("f3", 4'b0111, 1'b1, 1'b0);
    push("f4", 4'b1111, 1'b1, 1'b0);
    push("f5", 4'b0111, 1'b0, 1'b1);
    push("f6", 4'b0011, 1'b0, 1'b0);
    push("f7", 4'b0001, 1'b0, 1'b0);
    push("f8", 4'b0000, 1'b0, 1'b0);
    push("f9", 4'b0001, 1'b1, 1'b1);
    repeat (9) run_step();

    // Enable freeze during rotate
    do_reset(2'b00, 1'b1);
    push("en1", 4'b0001, 1'b1, 1'b1);
    run_step();
    tick(2);
    bus.en = 1'b0;
    tick(10);
    chk("frz_led", 8'(bus.led), 8'b0001);
    chk("frz_wrap", 8'(bus.wrap), 8'd0);
    bus.en = 1'b1;
    tick(1);
    chk("resume_hold", 8'(bus.led), 8'b0001);
    tick(1);
    chk("resume_step", 8'(bus.led), 8'b0010);

    // Mode change on a step edge wins over the step
    tick(3);
    bus.mode = 2'b01;
    tick(1);
    chk("mc_led", 8'(bus.led), 8'b1000);
    chk("mc_wrap", 8'(bus.wrap), 8'd0);
    push("mc1", 4'b0100, 1'b0, 1'b0);
    run_step();

    // Hold
    bus.mode = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("hold_led", 8'(bus.led), 8'b0100);
      chk("hold_wrap", 8'(bus.wrap), 8'd0);
    end

    // Async reset mid-bounce
    bus.mode = 2'b01;
    tick(6);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_led", 8'(bus.led), 8'b1000);
    chk("arst_wrap", 8'(bus.wrap), 8'd0);
    bus.mode = 2'b00;
    bus.dir  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    push("ar1", 4'b0001, 1'b1, 1'b1);
    run_step();

    chk("sb_drained", 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
